// File: rtl/bin_subtractor_serial_pkg.sv
// Shared arithmetic package: FSM encoding and the default operand width used
// by both the serial subtractor and the carry-lookahead adder.
package bin_arith_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef logic [1:0] state_t;

    localparam state_t IDLE = 2'd0;
    localparam state_t RUN  = 2'd1;
    localparam state_t DONE = 2'd2;

endpackage

// File: rtl/bin_subtractor_serial_if.sv
// Request/result bundle for bin_subtractor_serial. The ovf signal only exists
// when SUB_OVF_EN is defined.
interface bin_subtractor_serial_if #(parameter int WIDTH = bin_arith_pkg::DEFAULT_WIDTH);

    logic             start;
    logic [WIDTH-1:0] num1;
    logic [WIDTH-1:0] num2;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             borrow;
`ifdef SUB_OVF_EN
    logic             ovf;

    modport master (output start, num1, num2, input busy, done, diff, borrow, ovf);
    modport slave  (input start, num1, num2, output busy, done, diff, borrow, ovf);
`else
    modport master (output start, num1, num2, input busy, done, diff, borrow);
    modport slave  (input start, num1, num2, output busy, done, diff, borrow);
`endif

endinterface

// File: rtl/bin_subtractor_serial_full_subtractor.sv
// One-bit combinational full-subtractor cell; the subtraction counterpart of
// the adder's full_adder.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);

    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/bin_subtractor_serial.sv
// Bit-serial subtractor computing num1 - num2 LSB first with one full-subtractor
// cell and a registered borrow. Define SUB_OVF_EN to add the signed ovf output.
module bin_subtractor_serial
    import bin_arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    bin_subtractor_serial_if.slave  bus
);

    localparam int           CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] opA_q, opA_d;
    logic [WIDTH-1:0] opB_q, opB_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [CNT_W-1:0] bitCnt_q, bitCnt_d;
    logic             borrow_q, borrow_d;
    logic [WIDTH-1:0] diffOut_q, diffOut_d;
    logic             borrowOut_q, borrowOut_d;
    logic             fsD;
    logic             fsBout;

`ifdef SUB_OVF_EN
    logic             msbA_q, msbA_d;
    logic             msbB_q, msbB_d;
    logic             ovf_q, ovf_d;
`endif

    full_subtractor u_fs (
        .a    (opA_q[0]),
        .b    (opB_q[0]),
        .bin  (borrow_q),
        .d    (fsD),
        .bout (fsBout)
    );

    // Results only change on the final RUN edge, so diff/borrow never show partials.
    always_comb begin
        state_d     = state_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        result_d    = result_q;
        bitCnt_d    = bitCnt_q;
        borrow_d    = borrow_q;
        diffOut_d   = diffOut_q;
        borrowOut_d = borrowOut_q;
`ifdef SUB_OVF_EN
        msbA_d      = msbA_q;
        msbB_d      = msbB_q;
        ovf_d       = ovf_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d  = RUN;
                    opA_d    = bus.num1;
                    opB_d    = bus.num2;
                    result_d = '0;
                    bitCnt_d = '0;
                    borrow_d = 1'b0;
`ifdef SUB_OVF_EN
                    msbA_d   = bus.num1[WIDTH-1];
                    msbB_d   = bus.num2[WIDTH-1];
`endif
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                opA_d    = opA_q >> 1;
                opB_d    = opB_q >> 1;
                result_d = {fsD, result_q[WIDTH-1:1]};
                borrow_d = fsBout;
                bitCnt_d = bitCnt_q + CNT_W'(1);
                if (bitCnt_q == LAST_BIT) begin
                    state_d     = DONE;
                    diffOut_d   = result_d;
                    borrowOut_d = fsBout;
`ifdef SUB_OVF_EN
                    ovf_d       = (msbA_q != msbB_q) && (fsD != msbA_q);
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            opA_q       <= '0;
            opB_q       <= '0;
            result_q    <= '0;
            bitCnt_q    <= '0;
            borrow_q    <= 1'b0;
            diffOut_q   <= '0;
            borrowOut_q <= 1'b0;
`ifdef SUB_OVF_EN
            msbA_q      <= 1'b0;
            msbB_q      <= 1'b0;
            ovf_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            result_q    <= result_d;
            bitCnt_q    <= bitCnt_d;
            borrow_q    <= borrow_d;
            diffOut_q   <= diffOut_d;
            borrowOut_q <= borrowOut_d;
`ifdef SUB_OVF_EN
            msbA_q      <= msbA_d;
            msbB_q      <= msbB_d;
            ovf_q       <= ovf_d;
`endif
        end
    end

    assign bus.busy   = (state_q == RUN);
    assign bus.done   = (state_q == DONE);
    assign bus.diff   = diffOut_q;
    assign bus.borrow = borrowOut_q;
`ifdef SUB_OVF_EN
    assign bus.ovf    = ovf_q;
`endif

endmodule
